// File: rtl/bno055_i2c_target.sv
// bno055_i2c_target: I2C target that emulates the BNO055 register interface.
// Read-only chip-ID bytes at 0..3, writable scratch registers above them.
// Both bus lines are synchronized and glitch-filtered before any edge is used.
module bno055_i2c_target #(
   parameter logic [6:0] DEV_ADDR   = 7'h28,
   parameter int         NUM_REGS   = 8,
   parameter int         FILTER_LEN = 3
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_scl,
   input  logic       i_sda,
   output logic       o_sda_oe,
   output logic       o_wr_valid,
   output logic [7:0] o_wr_addr,
   output logic [7:0] o_wr_data,
   output logic       o_busy
);

   localparam int         IDX_W      = $clog2(NUM_REGS);
   localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
      S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT
   } state_t;

   // ---------------------------------------------------------------
   // Input conditioning: bit 0 = SCL, bit 1 = SDA
   // ---------------------------------------------------------------
   logic [1:0] pad_in;
   logic [1:0] filt;
   logic [1:0] filt_d;

   assign pad_in = {i_sda, i_scl};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cond
         logic                  meta_reg;
         logic                  sync_reg;
         logic [FILTER_LEN-2:0] hist_reg;
         logic                  filt_reg;
         logic                  filt_d_reg;
         logic [FILTER_LEN-1:0] window;

         // The newest synchronized sample plus history must all agree
         assign window = {hist_reg, sync_reg};

         // Synchronize, keep sample history, accept a level only when stable
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               meta_reg   <= 1'b1;
               sync_reg   <= 1'b1;
               hist_reg   <= '1;
               filt_reg   <= 1'b1;
               filt_d_reg <= 1'b1;
            end else begin
               meta_reg   <= pad_in[gi];
               sync_reg   <= meta_reg;
               hist_reg   <= window[FILTER_LEN-2:0];
               if (&window)
                  filt_reg <= 1'b1;
               else if (~|window)
                  filt_reg <= 1'b0;
               filt_d_reg <= filt_reg;
            end
         end

         assign filt[gi]   = filt_reg;
         assign filt_d[gi] = filt_d_reg;
      end
   endgenerate

   logic scl_rise, scl_fall, scl_high, sda_in, start_det, stop_det;

   assign sda_in    = filt[1];
   assign scl_rise  = filt[0] & ~filt_d[0];
   assign scl_fall  = ~filt[0] & filt_d[0];
   assign scl_high  = filt[0] & filt_d[0];
   assign start_det = scl_high & filt_d[1] & ~filt[1];
   assign stop_det  = scl_high & ~filt_d[1] & filt[1];

   // ---------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------
   state_t     state_reg,   state_next;
   logic [3:0] bit_cnt_reg, bit_cnt_next;
   logic [7:0] shift_reg,   shift_next;
   logic [7:0] ptr_reg,     ptr_next;
   logic       oe_reg,      oe_next;
   logic       busy_reg,    busy_next;
   logic       flag_reg,    flag_next;
   logic       wr_valid_reg, wr_valid_next;
   logic [7:0] wr_addr_reg, wr_addr_next;
   logic [7:0] wr_data_reg, wr_data_next;

   logic [7:0] regs [NUM_REGS];
   logic       reg_we;
   logic [7:0] shift_in;
   logic       in_range;
   logic       writable;
   logic [7:0] rd_byte;

   assign shift_in = {shift_reg[6:0], sda_in};
   assign in_range = {1'b0, ptr_reg} < NUM_REGS_W;
   assign writable = in_range && (ptr_reg >= 8'd4);
   assign rd_byte  = in_range ? regs[ptr_reg[IDX_W-1:0]] : 8'h00;

   // ---------------------------------------------------------------
   // Register file: 0..3 are constant chip-ID bytes, the rest writable
   // ---------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
         if (gi < 4) begin : g_ro
            localparam logic [7:0] ID_VAL = (gi == 0) ? 8'hA0 :
                                            (gi == 1) ? 8'hFB :
                                            (gi == 2) ? 8'h32 : 8'h0F;
            assign regs[gi] = ID_VAL;
         end else begin : g_rw
            logic [7:0] val_reg;

            // Scratch register: cleared by reset, loaded by an accepted write byte
            always_ff @(posedge i_clk or negedge i_rst_n) begin
               if (!i_rst_n)
                  val_reg <= 8'h00;
               else if (reg_we && (ptr_reg[IDX_W-1:0] == IDX_W'(gi)))
                  val_reg <= shift_in;
            end

            assign regs[gi] = val_reg;
         end
      end
   endgenerate

   // Next-state and datapath decisions; bus conditions override everything
   always_comb begin
      state_next    = state_reg;
      bit_cnt_next  = bit_cnt_reg;
      shift_next    = shift_reg;
      ptr_next      = ptr_reg;
      oe_next       = oe_reg;
      busy_next     = busy_reg;
      flag_next     = flag_reg;
      wr_valid_next = 1'b0;
      wr_addr_next  = wr_addr_reg;
      wr_data_next  = wr_data_reg;
      reg_we        = 1'b0;

      if (stop_det) begin
         state_next   = S_IDLE;
         busy_next    = 1'b0;
         oe_next      = 1'b0;
         bit_cnt_next = 4'd0;
      end else if (start_det) begin
         state_next   = S_ADDR;
         oe_next      = 1'b0;
         bit_cnt_next = 4'd0;
      end else begin
         case (state_reg)
            S_IDLE: ;
            S_ADDR: begin
               if (scl_rise) begin
                  shift_next   = shift_in;
                  bit_cnt_next = bit_cnt_reg + 4'd1;
               end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                  bit_cnt_next = 4'd0;
                  if (shift_reg[7:1] == DEV_ADDR) begin
                     oe_next    = 1'b1;
                     busy_next  = 1'b1;
                     state_next = S_ADDR_ACK;
                  end else begin
                     state_next = S_WAIT;
                  end
               end
            end
            S_ADDR_ACK: begin
               if (scl_fall) begin
                  bit_cnt_next = 4'd0;
                  if (shift_reg[0]) begin
                     // Read: first data bit goes out right after the ACK clock
                     shift_next = rd_byte;
                     oe_next    = ~rd_byte[7];
                     state_next = S_RD_DATA;
                  end else begin
                     oe_next    = 1'b0;
                     state_next = S_PTR;
                  end
               end
            end
            S_PTR: begin
               if (scl_rise) begin
                  shift_next   = shift_in;
                  bit_cnt_next = bit_cnt_reg + 4'd1;
                  if (bit_cnt_reg == 4'd7)
                     ptr_next = shift_in;
               end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                  bit_cnt_next = 4'd0;
                  oe_next      = 1'b1;
                  state_next   = S_PTR_ACK;
               end
            end
            S_PTR_ACK, S_WR_ACK: begin
               if (scl_fall) begin
                  oe_next      = 1'b0;
                  bit_cnt_next = 4'd0;
                  state_next   = S_WR_DATA;
               end
            end
            S_WR_DATA: begin
               if (scl_rise) begin
                  shift_next   = shift_in;
                  bit_cnt_next = bit_cnt_reg + 4'd1;
                  if (bit_cnt_reg == 4'd7) begin
                     // Last bit of the byte: commit now, ACK decision held in flag
                     flag_next = writable;
                     if (writable) begin
                        reg_we        = 1'b1;
                        wr_valid_next = 1'b1;
                        wr_addr_next  = ptr_reg;
                        wr_data_next  = shift_in;
                     end
                     ptr_next = ptr_reg + 8'd1;
                  end
               end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                  bit_cnt_next = 4'd0;
                  oe_next      = flag_reg;
                  state_next   = S_WR_ACK;
               end
            end
            S_RD_DATA: begin
               if (scl_rise) begin
                  bit_cnt_next = bit_cnt_reg + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt_reg == 4'd8) begin
                     oe_next      = 1'b0;
                     bit_cnt_next = 4'd0;
                     flag_next    = 1'b0;
                     state_next   = S_RD_ACK;
                  end else begin
                     oe_next    = ~shift_reg[6];
                     shift_next = {shift_reg[6:0], 1'b0};
                  end
               end
            end
            S_RD_ACK: begin
               if (scl_rise) begin
                  // Every byte handed out advances the pointer
                  ptr_next = ptr_reg + 8'd1;
                  if (sda_in)
                     state_next = S_WAIT;
                  else
                     flag_next = 1'b1;
               end else if (scl_fall && flag_reg) begin
                  flag_next    = 1'b0;
                  bit_cnt_next = 4'd0;
                  shift_next   = rd_byte;
                  oe_next      = ~rd_byte[7];
                  state_next   = S_RD_DATA;
               end
            end
            S_WAIT: oe_next = 1'b0;
            default: state_next = S_IDLE;
         endcase
      end
   end

   // State register; reset releases SDA and clears the pointer immediately
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg    <= S_IDLE;
         bit_cnt_reg  <= 4'd0;
         shift_reg    <= 8'h00;
         ptr_reg      <= 8'h00;
         oe_reg       <= 1'b0;
         busy_reg     <= 1'b0;
         flag_reg     <= 1'b0;
         wr_valid_reg <= 1'b0;
         wr_addr_reg  <= 8'h00;
         wr_data_reg  <= 8'h00;
      end else begin
         state_reg    <= state_next;
         bit_cnt_reg  <= bit_cnt_next;
         shift_reg    <= shift_next;
         ptr_reg      <= ptr_next;
         oe_reg       <= oe_next;
         busy_reg     <= busy_next;
         flag_reg     <= flag_next;
         wr_valid_reg <= wr_valid_next;
         wr_addr_reg  <= wr_addr_next;
         wr_data_reg  <= wr_data_next;
      end
   end

   assign o_sda_oe   = oe_reg;
   assign o_busy     = busy_reg;
   assign o_wr_valid = wr_valid_reg;
   assign o_wr_addr  = wr_addr_reg;
   assign o_wr_data  = wr_data_reg;

endmodule

// File: tb/tb_bno055_i2c_target.sv
// tb_bno055_i2c_target: bit-banged I2C master driving the BNO055 target.
// Expected ACK bits, read bytes and write pulses are queued before each
// transfer; separate monitors pop and compare as results appear.
`timescale 1ns/1ps
module tb_bno055_i2c_target;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_drv = 1'b1;
   logic       sda_drv = 1'b1;
   logic       sda_bus;
   logic       o_sda_oe, o_wr_valid, o_busy;
   logic [7:0] o_wr_addr, o_wr_data;

   int vec_cnt = 0;
   int err_cnt = 0;
   int oe_cnt  = 0;

   typedef struct {
      string       name;
      logic [15:0] val;
   } item_t;

   item_t       exp_q[$];
   item_t       obs_q[$];
   logic [15:0] exp_wr_q[$];

   assign sda_bus = sda_drv & ~o_sda_oe;

   bno055_i2c_target #(.DEV_ADDR(7'h28), .NUM_REGS(8), .FILTER_LEN(3)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_scl     (scl_drv),
      .i_sda     (sda_bus),
      .o_sda_oe  (o_sda_oe),
      .o_wr_valid(o_wr_valid),
      .o_wr_addr (o_wr_addr),
      .o_wr_data (o_wr_data),
      .o_busy    (o_busy)
   );

   always #5 clk = ~clk;

   // Count cycles in which the target pulls SDA
   always @(negedge clk) if (o_sda_oe) oe_cnt = oe_cnt + 1;

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end else begin
         $display("ok   %s: %h", nm, act);
      end
   endtask

   // Bus-result monitor
   initial begin
      item_t e, o;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check(e.name, o.val, e.val);
         end
      end
   end

   // Register-write monitor
   initial begin
      forever begin
         @(negedge clk);
         if (o_wr_valid) begin
            if (exp_wr_q.size() == 0) begin
               vec_cnt++;
               err_cnt++;
               $display("FAIL wr_unexpected: got %h/%h, expected no write", o_wr_addr, o_wr_data);
            end else begin
               check("wr_pulse", {o_wr_addr, o_wr_data}, exp_wr_q.pop_front());
            end
         end
      end
   end

   // Quarter SCL period
   task automatic q();
      repeat (8) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_drv = 1'b1; q();
      scl_drv = 1'b1; q();
      sda_drv = 1'b0; q();
      scl_drv = 1'b0; q();
   endtask

   task automatic i2c_stop();
      sda_drv = 1'b0; q();
      scl_drv = 1'b1; q();
      sda_drv = 1'b1; q();
   endtask

   task automatic write_bit(input logic b);
      sda_drv = b;    q();
      scl_drv = 1'b1; q(); q();
      scl_drv = 1'b0; q();
   endtask

   // Same as write_bit but with a one-cycle inverted SDA pulse while SCL is high
   task automatic write_bit_glitch(input logic b);
      sda_drv = b;    q();
      scl_drv = 1'b1; q();
      sda_drv = ~b;   @(negedge clk);
      sda_drv = b;    q();
      scl_drv = 1'b0; q();
   endtask

   task automatic read_bit(output logic b);
      sda_drv = 1'b1; q();
      scl_drv = 1'b1; q();
      b = sda_bus;    q();
      scl_drv = 1'b0; q();
   endtask

   task automatic send(input logic [7:0] b, input logic exp_ack, input string nm);
      logic ack;
      exp_q.push_back('{name: nm, val: 16'(exp_ack)});
      for (int i = 7; i >= 0; i--) write_bit(b[i]);
      read_bit(ack);
      obs_q.push_back('{name: nm, val: 16'(ack)});
   endtask

   task automatic recv(input logic [7:0] exp, input logic nack, input string nm);
      logic [7:0] b;
      logic       x;
      exp_q.push_back('{name: nm, val: 16'(exp)});
      for (int i = 7; i >= 0; i--) begin
         read_bit(x);
         b[i] = x;
      end
      write_bit(nack);
      obs_q.push_back('{name: nm, val: 16'(b)});
   endtask

   // Set pointer then repeated-START into a read
   task automatic set_ptr_read(input logic [7:0] p, input string nm);
      i2c_start();
      send(8'h50, 1'b0, {nm, "_aw"});
      send(p,     1'b0, {nm, "_ptr"});
      i2c_start();
      send(8'h51, 1'b0, {nm, "_ar"});
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time exceeded, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int oe_before;
      logic ack;

      // Reset state
      repeat (5) @(negedge clk);
      check("rst_oe",       16'(o_sda_oe),   16'h0);
      check("rst_busy",     16'(o_busy),     16'h0);
      check("rst_wr_valid", 16'(o_wr_valid), 16'h0);
      check("rst_wr_addr",  16'(o_wr_addr),  16'h0);
      check("rst_wr_data",  16'(o_wr_data),  16'h0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // Chip-ID read
      set_ptr_read(8'h00, "id");
      recv(8'hA0, 1'b1, "id_byte");
      check("id_busy_before_stop", 16'(o_busy), 16'h1);
      i2c_stop();
      repeat (10) @(negedge clk);
      check("id_busy_after_stop", 16'(o_busy), 16'h0);

      // Writes to scratch registers 5 and 6
      i2c_start();
      send(8'h50, 1'b0, "wr_aw");
      send(8'h05, 1'b0, "wr_ptr");
      exp_wr_q.push_back(16'h053C);
      exp_wr_q.push_back(16'h067E);
      send(8'h3C, 1'b0, "wr_d0_ack");
      send(8'h7E, 1'b0, "wr_d1_ack");
      i2c_stop();

      // Read back
      set_ptr_read(8'h05, "rb");
      recv(8'h3C, 1'b0, "rb_reg5");
      recv(8'h7E, 1'b1, "rb_reg6");
      i2c_stop();

      // Burst read from 0
      set_ptr_read(8'h00, "burst");
      recv(8'hA0, 1'b0, "burst_reg0");
      recv(8'hFB, 1'b0, "burst_reg1");
      recv(8'h32, 1'b0, "burst_reg2");
      recv(8'h0F, 1'b0, "burst_reg3");
      recv(8'h00, 1'b1, "burst_reg4");
      i2c_stop();

      // Current-address read: pointer must now be 5
      i2c_start();
      send(8'h51, 1'b0, "cur_ar");
      recv(8'h3C, 1'b1, "cur_reg5");
      i2c_stop();

      // Protected write and check value unchanged
      i2c_start();
      send(8'h50, 1'b0, "prot_aw");
      send(8'h01, 1'b0, "prot_ptr");
      send(8'h55, 1'b1, "prot_nack");
      i2c_stop();
      set_ptr_read(8'h01, "prot_rb");
      recv(8'hFB, 1'b1, "prot_reg1");
      i2c_stop();

      // Out-of-range write and read
      i2c_start();
      send(8'h50, 1'b0, "oor_aw");
      send(8'h20, 1'b0, "oor_ptr");
      send(8'hAA, 1'b1, "oor_nack");
      i2c_stop();
      set_ptr_read(8'h20, "oor_rb");
      recv(8'h00, 1'b1, "oor_byte");
      i2c_stop();

      // Pointer wrap FF -> 00
      set_ptr_read(8'hFF, "wrap");
      recv(8'h00, 1'b0, "wrap_ff");
      recv(8'hA0, 1'b1, "wrap_00");
      i2c_stop();

      // Address mismatch
      oe_before = oe_cnt;
      i2c_start();
      send(8'h52, 1'b1, "mm_addr_nack");
      send(8'h00, 1'b1, "mm_data_nack");
      check("mm_busy", 16'(o_busy), 16'h0);
      i2c_stop();
      repeat (10) @(negedge clk);
      check("mm_oe_cycles", 16'(oe_cnt - oe_before), 16'h0);

      // Glitches on every pointer bit while SCL is high
      i2c_start();
      send(8'h50, 1'b0, "gl_aw");
      begin
         logic [7:0] p;
         p = 8'h03;
         exp_q.push_back('{name: "gl_ptr_ack", val: 16'h0});
         for (int i = 7; i >= 0; i--) write_bit_glitch(p[i]);
         read_bit(ack);
         obs_q.push_back('{name: "gl_ptr_ack", val: 16'(ack)});
      end
      check("gl_busy", 16'(o_busy), 16'h1);
      i2c_start();
      send(8'h51, 1'b0, "gl_ar");
      recv(8'h0F, 1'b1, "gl_reg3");
      i2c_stop();

      // Reset while the target drives a 0 data bit
      set_ptr_read(8'h03, "mr");
      sda_drv = 1'b1;
      begin
         int n;
         n = 0;
         while (!o_sda_oe && n < 100) begin
            @(negedge clk);
            n++;
         end
      end
      check("mr_oe_driven", 16'(o_sda_oe), 16'h1);
      rst_n = 1'b0;
      #1;
      check("mr_oe_release", 16'(o_sda_oe), 16'h0);
      check("mr_busy", 16'(o_busy), 16'h0);
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      scl_drv = 1'b1; q();
      sda_drv = 1'b1; q(); q();

      set_ptr_read(8'h00, "post_rst");
      recv(8'hA0, 1'b1, "post_rst_reg0");
      i2c_stop();
      set_ptr_read(8'h05, "post_rst5");
      recv(8'h00, 1'b1, "post_rst_reg5");
      i2c_stop();

      repeat (20) @(negedge clk);
      check("sb_drain", 16'(exp_q.size() + obs_q.size() + exp_wr_q.size()), 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
